// File: rtl/ctrl_tx_frame.sv
// ctrl_tx_frame: frames RF bytes and multi-byte ALU results onto a UART byte interface
// Ports: clk/rst (async, active-high); UART_TX_busy from the transmitter;
//   RF_SEND_TX_FLAG/RF_SEND_TX and ALU_SEND_FLAG/ALU_OUT_LATCHED request strobes + data;
//   P_DATA/UART_TX_VALID registered byte to UART; CTRL_TX_BUSY while framing or pending;
//   FRAME_DONE one-cycle pulse after the last byte of a frame.
module ctrl_tx_frame #(
  parameter int BYTE_W = 8,
  parameter int ALU_W = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              UART_TX_busy,
  input  logic              RF_SEND_TX_FLAG,
  input  logic [BYTE_W-1:0] RF_SEND_TX,
  input  logic              ALU_SEND_FLAG,
  input  logic [ALU_W-1:0]  ALU_OUT_LATCHED,
  output logic [BYTE_W-1:0] P_DATA,
  output logic              UART_TX_VALID,
  output logic              CTRL_TX_BUSY,
  output logic              FRAME_DONE
);
  localparam int NB = ALU_W / BYTE_W;
  localparam int CW = $clog2(NB) + 1;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_TX} state_t;
  state_t state_q, state_d;
  logic [BYTE_W-1:0] rf_buf_q, p_data_q, p_data_d, byte_d;
  logic [ALU_W-1:0] alu_buf_q, shift_q, shift_d, rf_frame;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rf_pend_q, alu_pend_q, valid_q, valid_d, done_q, done_d, rf_take, alu_take;
  // RF byte sits at the emitting end of the shift register
  assign rf_frame = MSB_FIRST ? ALU_W'(rf_buf_q) << (ALU_W - BYTE_W) : ALU_W'(rf_buf_q);
  always_comb begin
    state_d = IDLE;
    shift_d = shift_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    rf_take = 1'b0;
    alu_take = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = (rf_pend_q || alu_pend_q) && !UART_TX_busy ? SEND : IDLE;
        rf_take = state_d == SEND && rf_pend_q;
        alu_take = state_d == SEND && !rf_pend_q;
        shift_d = rf_take ? rf_frame : alu_take ? alu_buf_q : shift_q;
        cnt_d = rf_take ? CW'(1) : alu_take ? CW'(NB) : cnt_q;
      end
      SEND: state_d = UART_TX_busy ? WAIT_TX : SEND;
      WAIT_TX: begin
        state_d = UART_TX_busy ? WAIT_TX : cnt_q > CW'(1) ? SEND : IDLE;
        done_d = !UART_TX_busy && cnt_q <= CW'(1);
        shift_d = state_d == SEND ? (MSB_FIRST ? shift_q << BYTE_W : shift_q >> BYTE_W) : shift_q;
        cnt_d = state_d == SEND ? cnt_q - CW'(1) : cnt_q;
      end
      default: state_d = IDLE;
    endcase
    byte_d = MSB_FIRST ? shift_d[ALU_W-1 -: BYTE_W] : shift_d[BYTE_W-1:0];
    valid_d = state_d == SEND;
    p_data_d = valid_d ? byte_d : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q <= '0;
      rf_buf_q <= '0;
      alu_buf_q <= '0;
      rf_pend_q <= 1'b0;
      alu_pend_q <= 1'b0;
      p_data_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      rf_buf_q <= RF_SEND_TX_FLAG ? RF_SEND_TX : rf_buf_q;
      alu_buf_q <= ALU_SEND_FLAG ? ALU_OUT_LATCHED : alu_buf_q;
      // a fresh strobe wins over the clear of a request being taken this cycle
      rf_pend_q <= RF_SEND_TX_FLAG || (rf_pend_q && !rf_take);
      alu_pend_q <= ALU_SEND_FLAG || (alu_pend_q && !alu_take);
      p_data_q <= p_data_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
  assign P_DATA = p_data_q;
  assign UART_TX_VALID = valid_q;
  assign FRAME_DONE = done_q;
  assign CTRL_TX_BUSY = state_q != IDLE || rf_pend_q || alu_pend_q;
endmodule

// File: tb/tb_ctrl_tx_frame.sv
// tb_ctrl_tx_frame: directed bench for ctrl_tx_frame (16-bit LSB-first and 32-bit MSB-first)
module tb_ctrl_tx_frame;
  logic clk, rst;
  logic rf_f1, alu_f1, rf_f2, alu_f2, hold1;
  logic [7:0] rf_d1, rf_d2;
  logic [15:0] alu_d1;
  logic [31:0] alu_d2;
  logic ub1, ub2, busy1;
  int ucnt1, ucnt2;
  logic [7:0] pd1, pd2;
  logic v1, v2, cb1, cb2, dn1, dn2, pv1, pv2;
  logic [7:0] q1[$], q2[$];
  int errors = 0, checks = 0;
  assign busy1 = ub1 | hold1;
  ctrl_tx_frame #(.BYTE_W(8), .ALU_W(16), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .UART_TX_busy(busy1),
    .RF_SEND_TX_FLAG(rf_f1), .RF_SEND_TX(rf_d1),
    .ALU_SEND_FLAG(alu_f1), .ALU_OUT_LATCHED(alu_d1),
    .P_DATA(pd1), .UART_TX_VALID(v1), .CTRL_TX_BUSY(cb1), .FRAME_DONE(dn1));
  ctrl_tx_frame #(.BYTE_W(8), .ALU_W(32), .MSB_FIRST(1'b1)) dut2 (
    .clk(clk), .rst(rst), .UART_TX_busy(ub2),
    .RF_SEND_TX_FLAG(rf_f2), .RF_SEND_TX(rf_d2),
    .ALU_SEND_FLAG(alu_f2), .ALU_OUT_LATCHED(alu_d2),
    .P_DATA(pd2), .UART_TX_VALID(v2), .CTRL_TX_BUSY(cb2), .FRAME_DONE(dn2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // UART model: busy rises the cycle after VALID is seen, stays high 10 cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ub1 <= 1'b0; ucnt1 <= 0; ub2 <= 1'b0; ucnt2 <= 0;
    end else begin
      if (ub1) begin ub1 <= ucnt1 != 1; ucnt1 <= ucnt1 - 1; end
      else if (v1) begin ub1 <= 1'b1; ucnt1 <= 10; end
      if (ub2) begin ub2 <= ucnt2 != 1; ucnt2 <= ucnt2 - 1; end
      else if (v2) begin ub2 <= 1'b1; ucnt2 <= 10; end
    end
  end
  // byte capture on each VALID assertion
  always @(negedge clk) begin
    if (v1 && !pv1) q1.push_back(pd1);
    if (v2 && !pv2) q2.push_back(pd2);
    pv1 <= v1;
    pv2 <= v2;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // count FRAME_DONE pulses until n seen (bounded), then a quiet window for extras
  task automatic run_frames(input int n, input bit which, input string tag);
    int got = 0;
    for (int i = 0; i < 2000 && got < n; i++) begin
      @(negedge clk);
      got += which ? int'(dn2) : int'(dn1);
    end
    repeat (30) begin
      @(negedge clk);
      got += which ? int'(dn2) : int'(dn1);
    end
    check(tag, got, n);
  endtask
  initial begin
    rst = 1'b1; hold1 = 1'b0; pv1 = 1'b0; pv2 = 1'b0;
    rf_f1 = 0; alu_f1 = 0; rf_f2 = 0; alu_f2 = 0;
    rf_d1 = '0; rf_d2 = '0; alu_d1 = '0; alu_d2 = '0;
    repeat (2) @(negedge clk);
    check("rst_pdata", pd1, 0);
    check("rst_valid", v1, 0);
    check("rst_busy", cb1, 0);
    check("rst_done", dn1, 0);
    check("rst2_out", {pd2, v2, cb2, dn2}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // RF single byte with latency checks
    rf_d1 = 8'hA5; rf_f1 = 1;
    @(negedge clk); rf_f1 = 0;
    check("rf_k1_valid", v1, 0);
    check("rf_k1_busy", cb1, 1);
    @(negedge clk);
    check("rf_k2_valid", v1, 1);
    check("rf_k2_data", pd1, 8'hA5);
    @(negedge clk);
    check("rf_hold", {busy1, v1, pd1}, {1'b1, 1'b1, 8'hA5});
    @(negedge clk);
    check("rf_drop", {v1, pd1}, 0);
    run_frames(1, 0, "rf_done");
    check("rf_nbytes", q1.size(), 1);
    check("rf_byte", q1[0], 8'hA5);
    check("rf_idle_busy", cb1, 0);
    // ALU 0xBEEF, LSB first
    q1.delete();
    @(negedge clk); alu_d1 = 16'hBEEF; alu_f1 = 1;
    @(negedge clk); alu_f1 = 0;
    run_frames(1, 0, "alu_done");
    check("alu_nbytes", q1.size(), 2);
    check("alu_b0", q1[0], 8'hEF);
    check("alu_b1", q1[1], 8'hBE);
    // 32-bit MSB first ALU, then RF on the same instance
    @(negedge clk); alu_d2 = 32'h12345678; alu_f2 = 1;
    @(negedge clk); alu_f2 = 0;
    run_frames(1, 1, "alu32_done");
    check("alu32_nbytes", q2.size(), 4);
    check("alu32_bytes", {q2[0], q2[1], q2[2], q2[3]}, 32'h12345678);
    q2.delete();
    @(negedge clk); rf_d2 = 8'h5A; rf_f2 = 1;
    @(negedge clk); rf_f2 = 0;
    run_frames(1, 1, "rf_msb_done");
    check("rf_msb_nbytes", q2.size(), 1);
    check("rf_msb_byte", q2[0], 8'h5A);
    // simultaneous RF and ALU strobes
    q1.delete();
    begin
      int nd = 0;
      bit dropped = 0;
      @(negedge clk); rf_d1 = 8'h3C; alu_d1 = 16'h0102; rf_f1 = 1; alu_f1 = 1;
      @(negedge clk); rf_f1 = 0; alu_f1 = 0;
      for (int i = 0; i < 2000; i++) begin
        if (!cb1) dropped = 1;
        @(negedge clk);
        nd += int'(dn1);
        if (nd == 2) break;
      end
      check("sim_done", nd, 2);
      check("sim_busy_held", dropped, 0);
    end
    repeat (5) @(negedge clk);
    check("sim_nbytes", q1.size(), 3);
    check("sim_bytes", {q1[0], q1[1], q1[2]}, 24'h3C0201);
    // RF request arriving during the second ALU byte
    q1.delete();
    @(negedge clk); alu_d1 = 16'hCAFE; alu_f1 = 1;
    @(negedge clk); alu_f1 = 0;
    for (int i = 0; i < 500 && q1.size() < 2; i++) @(posedge clk);
    @(negedge clk); rf_d1 = 8'h77; rf_f1 = 1;
    @(negedge clk); rf_f1 = 0;
    run_frames(2, 0, "mid_done");
    check("mid_nbytes", q1.size(), 3);
    check("mid_bytes", {q1[0], q1[1], q1[2]}, 24'hFECA77);
    // start gated by UART busy already high
    q1.delete();
    begin
      bit early = 0;
      @(negedge clk); hold1 = 1; rf_d1 = 8'h11; rf_f1 = 1;
      @(negedge clk); rf_f1 = 0;
      repeat (6) begin
        @(negedge clk);
        if (v1) early = 1;
      end
      check("gate_no_valid", early, 0);
      check("gate_pending", cb1, 1);
      hold1 = 0;
    end
    run_frames(1, 0, "gate_done");
    check("gate_byte", {q1.size() == 1, q1.size() > 0 ? q1[0] : 8'h00}, {1'b1, 8'h11});
    // async reset while in WAIT_TX with an RF request pending
    q1.delete();
    @(negedge clk); alu_d1 = 16'hBEEF; alu_f1 = 1;
    @(negedge clk); alu_f1 = 0;
    for (int i = 0; i < 500 && !(q1.size() == 1 && ub1 && !v1); i++) @(negedge clk);
    rf_d1 = 8'h99; rf_f1 = 1;
    @(negedge clk); rf_f1 = 0;
    check("prerst_wait", {v1, cb1}, 2'b01);
    #2 rst = 1;
    #1;
    check("arst_out", {pd1, v1, cb1, dn1}, 0);
    @(negedge clk); rst = 0;
    run_frames(0, 0, "arst_no_done");
    check("arst_no_bytes", q1.size(), 1);
    check("arst_idle", cb1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
